// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared sizes, types and address helpers for the instruction cache
// Contents: index/tag widths, line count, FSM state encoding, index/tag extraction.
package inst_cache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 8;
  localparam int ICACHE_TAG_WIDTH   = 32 - ICACHE_INDEX_WIDTH - 2;
  localparam int ICACHE_LINES       = 1 << ICACHE_INDEX_WIDTH;

  typedef logic [ICACHE_INDEX_WIDTH-1:0] ic_index_t;
  typedef logic [ICACHE_TAG_WIDTH-1:0]   ic_tag_t;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_RESP = 2'd1,
    IC_MISS = 2'd2
  } ic_state_e;

  function automatic ic_index_t ic_index(input logic [31:0] addr);
    return addr[ICACHE_INDEX_WIDTH+1:2];
  endfunction

  function automatic ic_tag_t ic_tag(input logic [31:0] addr);
    return addr[31:ICACHE_INDEX_WIDTH+2];
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - direct-mapped valid/tag/data storage for the instruction cache
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid bits only)
//   rdy                 global enable; writes happen only when high
//   wr_en/wr_index/...  synchronous line write (valid set, tag, data)
//   rd_index            combinational read index
//   rd_valid/rd_tag/rd_data  contents of the addressed line
module inst_cache_array
  import inst_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        wr_en,
  input  ic_index_t   wr_index,
  input  ic_tag_t     wr_tag,
  input  logic [31:0] wr_data,
  input  ic_index_t   rd_index,
  output logic        rd_valid,
  output ic_tag_t     rd_tag,
  output logic [31:0] rd_data
);

  logic [ICACHE_LINES-1:0] valid_q;
  ic_tag_t                 tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && rdy && wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped word-per-line instruction cache between fetch and memory controller
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; low freezes all state and outputs
//   IF_inst_read_valid       fetch request (level)
//   IF_inst_addr             fetch byte address (word aligned)
//   IF_inst_valid, IF_inst   one-cycle response pulse and instruction word
//   MemCtrl_inst_read_valid  miss read request, held until data returns
//   MemCtrl_inst_addr        miss address
//   MemCtrl_inst_valid       fill data strobe
//   MemCtrl_inst             fill data
//   ROB_jump_judge           redirect/flush pulse
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_inst_read_valid,
  input  logic [31:0] IF_inst_addr,
  output logic        IF_inst_valid,
  output logic [31:0] IF_inst,
  output logic        MemCtrl_inst_read_valid,
  output logic [31:0] MemCtrl_inst_addr,
  input  logic        MemCtrl_inst_valid,
  input  logic [31:0] MemCtrl_inst,
  input  logic        ROB_jump_judge
);

  ic_state_e   state_q, state_d;
  logic        abort_q, abort_d;
  logic        if_valid_d;
  logic [31:0] if_inst_d;
  logic        mem_rd_d;
  logic [31:0] mem_addr_d;

  logic        arr_wr_en;
  logic        arr_valid;
  ic_tag_t     arr_tag;
  logic [31:0] arr_data;
  logic        hit;

  // MemCtrl_inst_addr is held for the whole miss, so it doubles as the
  // latched miss address used for the fill write.
  inst_cache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .wr_en    (arr_wr_en),
    .wr_index (ic_index(MemCtrl_inst_addr)),
    .wr_tag   (ic_tag(MemCtrl_inst_addr)),
    .wr_data  (MemCtrl_inst),
    .rd_index (ic_index(IF_inst_addr)),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data)
  );

  assign hit = arr_valid && (arr_tag == ic_tag(IF_inst_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                 <= IC_IDLE;
      abort_q                 <= 1'b0;
      IF_inst_valid           <= 1'b0;
      IF_inst                 <= '0;
      MemCtrl_inst_read_valid <= 1'b0;
      MemCtrl_inst_addr       <= '0;
    end else if (rdy) begin
      state_q                 <= state_d;
      abort_q                 <= abort_d;
      IF_inst_valid           <= if_valid_d;
      IF_inst                 <= if_inst_d;
      MemCtrl_inst_read_valid <= mem_rd_d;
      MemCtrl_inst_addr       <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    if_valid_d = 1'b0;  // responses are single-cycle pulses
    if_inst_d  = IF_inst;
    mem_rd_d   = MemCtrl_inst_read_valid;
    mem_addr_d = MemCtrl_inst_addr;
    arr_wr_en  = 1'b0;

    unique case (state_q)
      IC_IDLE: begin
        if (IF_inst_read_valid && !ROB_jump_judge) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_inst_d  = arr_data;
            state_d    = IC_RESP;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = IF_inst_addr & ~32'h3;
            abort_d    = 1'b0;
            state_d    = IC_MISS;
          end
        end
      end
      // Bubble cycle lets fetch advance its address before the next lookup.
      IC_RESP: begin
        state_d = IC_IDLE;
      end
      IC_MISS: begin
        if (ROB_jump_judge) begin
          abort_d = 1'b1;
        end
        // The fill always lands in the array, even when the response is dropped.
        if (MemCtrl_inst_valid) begin
          arr_wr_en = 1'b1;
          mem_rd_d  = 1'b0;
          if (!abort_q && !ROB_jump_judge) begin
            if_valid_d = 1'b1;
            if_inst_d  = MemCtrl_inst;
            state_d    = IC_RESP;
          end else begin
            state_d = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - scoreboard testbench for inst_cache
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_inst_read_valid;
  logic [31:0] IF_inst_addr;
  logic        IF_inst_valid;
  logic [31:0] IF_inst;
  logic        MemCtrl_inst_read_valid;
  logic [31:0] MemCtrl_inst_addr;
  logic        MemCtrl_inst_valid;
  logic [31:0] MemCtrl_inst;
  logic        ROB_jump_judge;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] sb[$];
  logic        live = 1'b0;

  always #5 clk = ~clk;

  // Outputs only change on edges where the cache was enabled and out of reset.
  always @(posedge clk) live <= rdy && !rst;

  inst_cache dut (
    .clk                     (clk),
    .rst                     (rst),
    .rdy                     (rdy),
    .IF_inst_read_valid      (IF_inst_read_valid),
    .IF_inst_addr            (IF_inst_addr),
    .IF_inst_valid           (IF_inst_valid),
    .IF_inst                 (IF_inst),
    .MemCtrl_inst_read_valid (MemCtrl_inst_read_valid),
    .MemCtrl_inst_addr       (MemCtrl_inst_addr),
    .MemCtrl_inst_valid      (MemCtrl_inst_valid),
    .MemCtrl_inst            (MemCtrl_inst),
    .ROB_jump_judge          (ROB_jump_judge)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (live) begin
        if (IF_inst_valid) begin
          chk("no_back_to_back", {31'd0, prev_v}, 32'd0);
          if (sb.size() == 0) begin
            chk("unexpected_resp", IF_inst, 32'hxxxx_xxxx);
          end else begin
            exp = sb.pop_front();
            chk("resp_data", IF_inst, exp);
          end
        end
        prev_v = IF_inst_valid;
      end
    end
  endtask

  // mode 0: normal fill; 1: flush before data; 2: flush on the fill edge.
  // Data is returned on the third edge after the request edge.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int mode);
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = a;
    tick();
    IF_inst_read_valid = 1'b0;
    chk("miss_read_valid", {31'd0, MemCtrl_inst_read_valid}, 32'd1);
    chk("miss_addr", MemCtrl_inst_addr, a);
    chk("miss_no_resp", {31'd0, IF_inst_valid}, 32'd0);
    tick();
    if (mode == 1) ROB_jump_judge = 1'b1;
    tick();
    ROB_jump_judge     = (mode == 2);
    MemCtrl_inst_valid = 1'b1;
    MemCtrl_inst       = d;
    if (mode == 0) sb.push_back(d);
    tick();
    MemCtrl_inst_valid = 1'b0;
    ROB_jump_judge     = 1'b0;
    chk("fill_resp_valid", {31'd0, IF_inst_valid}, (mode == 0) ? 32'd1 : 32'd0);
    chk("fill_read_drop", {31'd0, MemCtrl_inst_read_valid}, 32'd0);
    if (mode == 0) tick();
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = a;
    sb.push_back(d);
    tick();
    IF_inst_read_valid = 1'b0;
    chk("hit_valid", {31'd0, IF_inst_valid}, 32'd1);
    chk("hit_no_miss", {31'd0, MemCtrl_inst_read_valid}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    IF_inst_read_valid = 1'b0; IF_inst_addr = '0;
    MemCtrl_inst_valid = 1'b0; MemCtrl_inst = '0; ROB_jump_judge = 1'b0;
    fork
      monitor();
    join_none
    tick(); tick();
    rst = 1'b0;
    chk("rst_if_valid", {31'd0, IF_inst_valid}, 32'd0);
    chk("rst_if_inst", IF_inst, 32'd0);
    chk("rst_mem_rd", {31'd0, MemCtrl_inst_read_valid}, 32'd0);
    chk("rst_mem_addr", MemCtrl_inst_addr, 32'd0);

    // Cold miss then hit
    do_miss(32'h0000_0000, 32'h0000_0013, 0);
    do_hit(32'h0000_0000, 32'h0000_0013);

    // Conflict on index 1
    do_miss(32'h0000_0004, 32'h0010_0093, 0);
    do_miss(32'h0000_0404, 32'h0020_0113, 0);
    do_miss(32'h0000_0004, 32'h0010_0093, 0);
    do_hit(32'h0000_0004, 32'h0010_0093);

    // Flush during miss: no response, line still filled
    do_miss(32'h0000_0100, 32'h0030_0193, 1);
    do_hit(32'h0000_0100, 32'h0030_0193);

    // Flush coincident with fill, then an immediate hit shows IDLE and the write
    do_miss(32'h0000_0008, 32'h0040_0213, 2);

    // Held request: pulses every other cycle, rdy stall mid-response
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = 32'h0000_0008;
    sb.push_back(32'h0040_0213);
    tick();
    chk("stream_hit1", {31'd0, IF_inst_valid}, 32'd1);
    tick();
    chk("stream_bubble", {31'd0, IF_inst_valid}, 32'd0);
    sb.push_back(32'h0040_0213);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid_held", {31'd0, IF_inst_valid}, 32'd1);
      chk("stall_inst_held", IF_inst, 32'h0040_0213);
    end
    rdy = 1'b1;
    tick();
    chk("post_stall_bubble", {31'd0, IF_inst_valid}, 32'd0);
    sb.push_back(32'h0040_0213);
    tick();
    chk("stream_hit3", {31'd0, IF_inst_valid}, 32'd1);
    IF_inst_read_valid = 1'b0;
    tick();

    // Reset mid-miss
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = 32'h0000_0010;
    tick();
    IF_inst_read_valid = 1'b0;
    chk("pre_rst_miss", {31'd0, MemCtrl_inst_read_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_if_valid", {31'd0, IF_inst_valid}, 32'd0);
    chk("mid_rst_if_inst", IF_inst, 32'd0);
    chk("mid_rst_mem_rd", {31'd0, MemCtrl_inst_read_valid}, 32'd0);
    chk("mid_rst_mem_addr", MemCtrl_inst_addr, 32'd0);
    do_miss(32'h0000_0000, 32'h0000_0013, 0);

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
